// File: rtl/vga_pkg.sv
// vga_pkg: shared VRAM widths, frame timing bounds and arbiter state type
package vga_pkg;
  localparam int VRAM_ADDR_W = 20;
  localparam int VRAM_DATA_W = 12;
  // last hcount of a line (1344-clock XGA line, counted 0..1343)
  localparam int HBLANK_STOP = 1343;
  // total lines per frame (806-line XGA frame, counted 0..805)
  localparam int VBLANK_STOP = 806;
  typedef enum logic [1:0] {ACTIVE, ARB, GRANT_A, GRANT_B} arb_state_t;
endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: timing inputs, two writer ports, VRAM write port and display read port
interface vram_arbiter_if import vga_pkg::*; #(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
);
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic hblnk;
  logic vblnk;
  logic req_a;
  logic req_b;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic gnt_a;
  logic gnt_b;
  logic mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic disp_rd_en;
  logic [ADDR_W-1:0] disp_rd_addr;
  logic frame_done;
  modport slave (
    input hcount, vcount, hblnk, vblnk, req_a, req_b, addr_a, addr_b, data_a, data_b,
    output gnt_a, gnt_b, mem_we, mem_waddr, mem_wdata, disp_rd_en, disp_rd_addr, frame_done
  );
  modport master (
    output hcount, vcount, hblnk, vblnk, req_a, req_b, addr_a, addr_b, data_a, data_b,
    input gnt_a, gnt_b, mem_we, mem_waddr, mem_wdata, disp_rd_en, disp_rd_addr, frame_done
  );
endinterface

// File: rtl/vram_win_gen.sv
// vram_win_gen: write window is vertical blank minus a guard band before the frame wraps
module vram_win_gen import vga_pkg::*; #(
  parameter int GUARD = 2
) (
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic        vblnk,
  output logic        win_open
);
  localparam logic [10:0] LAST_LINE = 11'(VBLANK_STOP - 1);
  localparam logic [10:0] CLOSE_H = 11'(HBLANK_STOP - 1 - GUARD);
  assign win_open = vblnk && !(vcount == LAST_LINE && hcount >= CLOSE_H);
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: round-robin burst arbiter for two VRAM writers during vertical blank
module vram_arbiter import vga_pkg::*; #(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W,
  parameter int MAX_BURST = 16,
  parameter int GUARD = 2
) (
  input logic clk,
  input logic rst_n,
  vram_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_BURST + 1);
  arb_state_t state, nxt;
  logic win_open, acc, last, rr_b;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  vram_win_gen #(.GUARD(GUARD)) u_win (
    .hcount(bus.hcount),
    .vcount(bus.vcount),
    .vblnk(bus.vblnk),
    .win_open(win_open)
  );
  assign bus.gnt_a = state == GRANT_A;
  assign bus.gnt_b = state == GRANT_B;
  assign acc = (bus.req_a && bus.gnt_a) || (bus.req_b && bus.gnt_b);
  assign last = cnt == CW'(MAX_BURST - 1);
  assign waddr = bus.gnt_a ? bus.addr_a : bus.addr_b;
  assign wdata = bus.gnt_a ? bus.data_a : bus.data_b;
  // next state; a closed window forces ACTIVE from any state
  always_comb begin
    nxt = state;
    case (state)
      ACTIVE:  nxt = win_open ? ARB : ACTIVE;
      ARB:     nxt = bus.req_a && (!bus.req_b || !rr_b) ? GRANT_A : bus.req_b ? GRANT_B : ARB;
      GRANT_A: nxt = !bus.req_a || last ? ARB : GRANT_A;
      GRANT_B: nxt = !bus.req_b || last ? ARB : GRANT_B;
      default: nxt = ACTIVE;
    endcase
    if (!win_open) nxt = ACTIVE;
  end
  // state, burst count (zero outside a running grant) and rr pointer flipped on grant exit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACTIVE;
      cnt <= '0;
      rr_b <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (bus.gnt_a || bus.gnt_b) && nxt == state ? cnt + CW'(acc) : '0;
      rr_b <= bus.gnt_a && nxt != GRANT_A ? 1'b1 : bus.gnt_b && nxt != GRANT_B ? 1'b0 : rr_b;
    end
  end
  // VRAM write port: accepted transfer lands one cycle later, addr/data hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_we <= 1'b0;
      bus.mem_waddr <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_we <= acc;
      if (acc) begin
        bus.mem_waddr <= waddr;
        bus.mem_wdata <= wdata;
      end
    end
  end
  // display read port follows the raster with one cycle of latency, never stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.disp_rd_en <= 1'b0;
      bus.disp_rd_addr <= '0;
    end else begin
      bus.disp_rd_en <= !bus.hblnk && !bus.vblnk;
      bus.disp_rd_addr <= ADDR_W'({bus.vcount[9:0], bus.hcount[9:0]});
    end
  end
  // frame_done pulses once when the window closes on an arbitrating or granting FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.frame_done <= 1'b0;
    else bus.frame_done <= state != ACTIVE && nxt == ACTIVE;
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed raster scenarios with a write scoreboard and grant timing checks
module tb_vram_arbiter;
  import vga_pkg::*;
  typedef struct {
    logic [19:0] addr;
    logic [11:0] data;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_chk = 0, n_fail = 0, cyc = 0, fd_cnt = 0;
  int ia = 0, ib = 0, na = 0, nb = 0, h = 0, v = 0, base = 0, fd0 = 0;
  logic acc_a, acc_b;
  exp_t q[$];
  exp_t m;
  always #5 clk = ~clk;
  vram_arbiter_if bus ();
  vram_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic drive();
    bus.hcount = 11'(h);
    bus.vcount = 11'(v);
    bus.hblnk = h >= 1024;
    bus.vblnk = v >= 768;
    bus.req_a = ia < na;
    bus.req_b = ib < nb;
    bus.addr_a = 20'(32'h100 + ia);
    bus.data_a = 12'(32'hA00 + ia);
    bus.addr_b = 20'(32'h200 + ib);
    bus.data_b = 12'(32'hB00 + ib);
  endtask

  // writers advance on acceptance sampled mid-cycle; raster advances after each edge
  task automatic tick();
    @(negedge clk);
    acc_a = bus.req_a && bus.gnt_a;
    acc_b = bus.req_b && bus.gnt_b;
    @(posedge clk);
    #1;
    cyc++;
    if (acc_a) ia++;
    if (acc_b) ib++;
    if (h == 1343) begin
      h = 0;
      v = v == 805 ? 0 : v + 1;
    end else h++;
    drive();
  endtask

  task automatic jump(input int vv, input int hh);
    v = vv;
    h = hh;
    base = cyc;
    drive();
  endtask

  task automatic push(input bit w, input int i, input int c);
    exp_t e;
    e.addr = 20'((w ? 32'h200 : 32'h100) + i);
    e.data = 12'((w ? 32'hB00 : 32'hA00) + i);
    e.cyc = c;
    q.push_back(e);
  endtask

  // monitor: every VRAM write must match the next expected write, including its cycle
  always @(negedge clk) begin
    if (bus.frame_done === 1'b1) fd_cnt++;
    if (bus.mem_we === 1'b1) begin
      if (q.size() == 0) chk("unexpected_write", 32'(bus.mem_waddr), 32'hFFFFFFFF);
      else begin
        m = q.pop_front();
        chk("wr_addr", 32'(bus.mem_waddr), 32'(m.addr));
        chk("wr_data", 32'(bus.mem_wdata), 32'(m.data));
        chk("wr_cycle", cyc, m.cyc);
      end
    end
  end

  initial begin
    h = 200;
    v = 100;
    drive();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_gnt_a", 32'(bus.gnt_a), 0);
    chk("rst_gnt_b", 32'(bus.gnt_b), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_waddr", 32'(bus.mem_waddr), 0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    chk("rst_disp_en", 32'(bus.disp_rd_en), 0);
    chk("rst_disp_addr", 32'(bus.disp_rd_addr), 0);
    chk("rst_frame_done", 32'(bus.frame_done), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    // active video: requests are ignored, display port tracks the raster
    na = 5;
    drive();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("act_gnt_a", 32'(bus.gnt_a), 0);
      chk("act_disp_en", 32'(bus.disp_rd_en), 1);
      chk("act_disp_addr", 32'(bus.disp_rd_addr), 32'({10'd100, 10'(h - 1)}));
    end
    chk("act_no_accept", ia, 0);
    na = 0;
    drive();
    tick();
    // writer A alone: 16-word burst, one idle ARB cycle, next burst
    ia = 0;
    na = 20;
    jump(768, 0);
    for (int i = 0; i < 20; i++) push(0, i, base + 3 + i + (i >= 16 ? 1 : 0));
    for (int c = 0; c < 30; c++) begin
      chk("a_only_gnt_a", 32'(bus.gnt_a), 32'((c >= 2 && c <= 17) || (c >= 19 && c <= 23)));
      chk("a_only_gnt_b", 32'(bus.gnt_b), 0);
      if (c == 1) chk("vblank_disp_en", 32'(bus.disp_rd_en), 0);
      tick();
    end
    na = 0;
    jump(100, 0);
    repeat (3) tick();
    // both writers after reset: A, gap, B, gap, A ...
    #1 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ia = 0;
    ib = 0;
    na = 20;
    nb = 20;
    jump(768, 0);
    for (int i = 0; i < 16; i++) push(0, i, base + 3 + i);
    for (int i = 0; i < 16; i++) push(1, i, base + 20 + i);
    for (int i = 16; i < 20; i++) push(0, i, base + 21 + i);
    for (int i = 16; i < 20; i++) push(1, i, base + 27 + i);
    for (int c = 0; c < 50; c++) begin
      chk("rr_gnt_a", 32'(bus.gnt_a), 32'((c >= 2 && c <= 17) || (c >= 36 && c <= 40)));
      chk("rr_gnt_b", 32'(bus.gnt_b), 32'((c >= 19 && c <= 34) || (c >= 42 && c <= 46)));
      tick();
    end
    na = 0;
    nb = 0;
    jump(100, 0);
    repeat (3) tick();
    // reset mid B burst: grant and write drop at once, A wins after release
    ia = 0;
    ib = 0;
    nb = 10;
    jump(768, 0);
    push(1, 0, base + 3);
    repeat (4) tick();
    chk("pre_rst_gnt_b", 32'(bus.gnt_b), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_gnt_b", 32'(bus.gnt_b), 0);
    chk("rst_mid_mem_we", 32'(bus.mem_we), 0);
    na = 5;
    drive();
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) push(0, i, base + 9 + i);
    for (int i = 2; i < 10; i++) push(1, i, base + 14 + i);
    for (int c = 6; c < 26; c++) begin
      chk("post_rst_gnt_a", 32'(bus.gnt_a), 32'(c >= 8 && c <= 13));
      chk("post_rst_gnt_b", 32'(bus.gnt_b), 32'(c >= 15 && c <= 23));
      tick();
    end
    na = 0;
    nb = 0;
    jump(100, 0);
    repeat (3) tick();
    // window close at the end of line 805: last grant at hcount 1340
    ia = 0;
    na = 100;
    fd0 = fd_cnt;
    jump(805, 1330);
    for (int i = 0; i < 9; i++) push(0, i, base + 3 + i);
    for (int c = 0; c < 15; c++) begin
      chk("close_gnt_a", 32'(bus.gnt_a), 32'(c >= 2 && c <= 10));
      chk("close_frame_done", 32'(bus.frame_done), 32'(c == 11));
      tick();
    end
    chk("close_fd_pulses", fd_cnt - fd0, 1);
    chk("close_accepted", ia, 9);
    na = 0;
    drive();
    repeat (3) tick();
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
